// File: rtl/p2s_stream_scheduler_pkg.sv
// p2s_sched_pkg
// Shared types and helpers for the p2s_stream_scheduler slice.
//   sched_state_e : scheduler FSM states (IDLE, SEND)
//   beats()       : number of output beats per requester word
//   id_width()    : width of a requester index
// No ports (package).
package p2s_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_e;

    function automatic int beats(input int bus_num_i, input int bus_num_o);
        return bus_num_i / bus_num_o;
    endfunction

    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    localparam int DEF_N_REQ = 4;
    localparam int DEF_ID_W  = id_width(DEF_N_REQ);

endpackage

// File: rtl/p2s_stream_scheduler_if.sv
// p2s_stream_scheduler_if
// Bundles the requester side and the serial output side of the scheduler.
// Optional macro: P2S_SCHED_BACKPRESSURE_EN adds out_ready_i.
//   req_valid_i/req_data_i/req_ready_o : N_REQ requester handshakes
//   data_valid_o/data_o/src_id_o/last_o : serial beat stream
//   busy_o                              : scheduler is emitting a word
//   out_ready_i                         : consumer ready (backpressure build only)
//   dbg_state/dbg_rr_ptr                : FSM state and arbiter pointer for observation
// Modports: slave = scheduler side, master = environment side.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. A valid source keeps valid high and its data
// stable until that edge; ready may depend combinationally on valid.
interface p2s_stream_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_NUM_I  = 8,
    parameter int BUS_NUM_O  = 2,
    parameter int N_REQ      = 4
);
    import p2s_sched_pkg::*;

    localparam int ID_W = id_width(N_REQ);

    logic [N_REQ-1:0]                                req_valid_i;
    logic [N_REQ-1:0][BUS_NUM_I-1:0][DATA_WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]                                req_ready_o;
    logic                                            data_valid_o;
    logic [BUS_NUM_O-1:0][DATA_WIDTH-1:0]            data_o;
    logic [ID_W-1:0]                                 src_id_o;
    logic                                            last_o;
    logic                                            busy_o;
    sched_state_e                                    dbg_state;
    logic [ID_W-1:0]                                 dbg_rr_ptr;
`ifdef P2S_SCHED_BACKPRESSURE_EN
    logic                                            out_ready_i;

    modport slave (
        input  req_valid_i, req_data_i, out_ready_i,
        output req_ready_o, data_valid_o, data_o, src_id_o, last_o, busy_o,
               dbg_state, dbg_rr_ptr
    );
    modport master (
        output req_valid_i, req_data_i, out_ready_i,
        input  req_ready_o, data_valid_o, data_o, src_id_o, last_o, busy_o,
               dbg_state, dbg_rr_ptr
    );
`else
    modport slave (
        input  req_valid_i, req_data_i,
        output req_ready_o, data_valid_o, data_o, src_id_o, last_o, busy_o,
               dbg_state, dbg_rr_ptr
    );
    modport master (
        output req_valid_i, req_data_i,
        input  req_ready_o, data_valid_o, data_o, src_id_o, last_o, busy_o,
               dbg_state, dbg_rr_ptr
    );
`endif

endinterface

// File: rtl/p2s_stream_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after
// ptr, wrapping modulo N_REQ. The pointer register lives in the parent.
//   req       in  [N_REQ]  request vector
//   ptr       in  [ID_W]   highest-priority index
//   gnt_valid out          any request present
//   gnt_idx   out [ID_W]   chosen index (0 when gnt_valid is low)
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_idx
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = ID_W'((int'(ptr) + off) % N_REQ);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/p2s_stream_scheduler.sv
// p2s_stream_scheduler
// Round-robin shares one parallel-to-serial path between N_REQ requesters.
// A granted BUS_NUM_I-element word is emitted as BEATS = BUS_NUM_I/BUS_NUM_O
// beats; beat k carries elements k, k+BEATS, k+2*BEATS, ...
// Optional macro: P2S_SCHED_BACKPRESSURE_EN (beats wait for out_ready_i).
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous, active-high
//   bus   p2s_stream_scheduler_if.slave (requesters, beat stream, debug)
module p2s_stream_scheduler
    import p2s_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_NUM_I  = 8,
    parameter int BUS_NUM_O  = 2,
    parameter int N_REQ      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    p2s_stream_scheduler_if.slave        bus
);

    localparam int BEATS = beats(BUS_NUM_I, BUS_NUM_O);
    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    generate
        if ((BUS_NUM_O < 1) || (BUS_NUM_I % BUS_NUM_O != 0) || (BEATS < 2) || (N_REQ < 2)) begin : g_bad_cfg
            $fatal(1, "p2s_stream_scheduler: illegal BUS_NUM_I/BUS_NUM_O/N_REQ combination");
        end
    endgenerate

    sched_state_e                         state_q;
    logic [CNT_W-1:0]                     cnt_q;
    logic [BUS_NUM_I-1:0][DATA_WIDTH-1:0] hold_q;
    logic [ID_W-1:0]                      src_q;
    logic [ID_W-1:0]                      rr_ptr_q;
    logic                                 valid_q;
    logic                                 last_q;
    logic                                 busy_q;

    logic            gnt_valid;
    logic [ID_W-1:0] gnt_idx;
    logic            beat_acc;
    logic            grant_ok;
    logic            take;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req       (bus.req_valid_i),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

`ifdef P2S_SCHED_BACKPRESSURE_EN
    assign beat_acc = valid_q & bus.out_ready_i;
`else
    assign beat_acc = valid_q;
`endif

    // A new word may be taken when idle, or on the edge where the last beat
    // leaves, which gives back-to-back words with no bubble. Ready is held
    // low while reset is asserted so no handshake can be lost.
    assign grant_ok = (state_q == IDLE) || (beat_acc && last_q);
    assign take     = gnt_valid && grant_ok && !reset;

    always_comb begin
        bus.req_ready_o = '0;
        if (take) begin
            bus.req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Beat cnt_q takes element cnt_q + BEATS*i into lane i.
    always_comb begin
        for (int i = 0; i < BUS_NUM_O; i++) begin
            bus.data_o[i] = hold_q[int'(cnt_q) + BEATS * i];
        end
    end

    assign bus.data_valid_o = valid_q;
    assign bus.last_o       = last_q;
    assign bus.busy_o       = busy_q;
    assign bus.src_id_o     = src_q;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_rr_ptr   = rr_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                SEND: begin
                    if (beat_acc) begin
                        if (!last_q) begin
                            cnt_q  <= cnt_q + CNT_W'(1);
                            last_q <= ((cnt_q + CNT_W'(1)) == CNT_LAST);
                        end else if (!take) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A grant overrides whatever the case above scheduled.
            if (take) begin
                state_q  <= SEND;
                hold_q   <= bus.req_data_i[gnt_idx];
                src_q    <= gnt_idx;
                rr_ptr_q <= (gnt_idx == ID_LAST) ? '0 : gnt_idx + ID_W'(1);
                cnt_q    <= '0;
                valid_q  <= 1'b1;
                last_q   <= 1'b0;
                busy_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_p2s_stream_scheduler.sv
// tb_p2s_stream_scheduler
// Bench for p2s_stream_scheduler with N_REQ=4, DATA_WIDTH=8, BUS_NUM_I=8,
// BUS_NUM_O=2. Build with P2S_SCHED_BACKPRESSURE_EN to also cover stalls.
module tb_p2s_stream_scheduler;
    import p2s_sched_pkg::*;

    localparam int DW    = 8;
    localparam int BI    = 8;
    localparam int BO    = 2;
    localparam int NR    = 4;
    localparam int BEATS = BI / BO;
    localparam int BW    = 1 + 2 + BO * DW;   // {last, src, lanes}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    p2s_stream_scheduler_if #(.DATA_WIDTH(DW), .BUS_NUM_I(BI), .BUS_NUM_O(BO), .N_REQ(NR)) bus ();

    p2s_stream_scheduler #(.DATA_WIDTH(DW), .BUS_NUM_I(BI), .BUS_NUM_O(BO), .N_REQ(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- bench state ----------------
    logic [BI-1:0][DW-1:0] word [NR];
    logic [NR-1:0]         vld;
    logic [NR-1:0]         keep;
    logic                  out_rdy;

    logic [BW-1:0] exp_q[$];
    int            m_ptr;

    int obs_v[$];
    int obs_src[$];
    int obs_last[$];
    int obs_data[$];
    int obs_rdy[$];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] rdy;
        logic          dv;
        logic [7:0]    d0;
        logic [7:0]    d1;
        logic          last;
        logic          busy;
        logic [1:0]    src;
    } vec_t;

    vec_t tab[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [BI-1:0][DW-1:0] rand_word();
        logic [BI-1:0][DW-1:0] w;
        for (int e = 0; e < BI; e++) w[e] = DW'($urandom_range(0, 255));
        return w;
    endfunction

    // Beat k of requester g's word: lane i carries element k + BEATS*i.
    function automatic logic [BW-1:0] make_beat(input int g, input int k);
        logic [BO-1:0][DW-1:0] lanes;
        for (int i = 0; i < BO; i++) lanes[i] = word[g][k + BEATS * i];
        return {(k == BEATS - 1), 2'(g), lanes};
    endfunction

    task automatic drive();
        bus.req_valid_i = vld;
        for (int g = 0; g < NR; g++) bus.req_data_i[g] = word[g];
`ifdef P2S_SCHED_BACKPRESSURE_EN
        bus.out_ready_i = out_rdy;
`endif
    endtask

    task automatic clear_obs();
        obs_v.delete(); obs_src.delete(); obs_last.delete(); obs_data.delete(); obs_rdy.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vld = '0; keep = '0; out_rdy = 1'b1;
        drive();
        exp_q.delete();
        m_ptr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Compare outputs against the head of the expected beat queue.
    task automatic check_outputs();
        logic busy_exp;
        busy_exp = (exp_q.size() > 0);
        chk("data_valid", 32'(bus.data_valid_o), 32'(busy_exp));
        chk("busy", 32'(bus.busy_o), 32'(busy_exp));
        chk("state", 32'(bus.dbg_state), busy_exp ? 32'(SEND) : 32'(IDLE));
        chk("rr_ptr", 32'(bus.dbg_rr_ptr), 32'(m_ptr));
        if (exp_q.size() > 0) begin
            chk("data", 32'(bus.data_o), 32'(exp_q[0][BO*DW-1:0]));
            chk("src_id", 32'(bus.src_id_o), 32'(exp_q[0][BW-2 -: 2]));
            chk("last", 32'(bus.last_o), 32'(exp_q[0][BW-1]));
        end else begin
            chk("last_idle", 32'(bus.last_o), 32'd0);
        end
        obs_v.push_back(int'(bus.data_valid_o));
        obs_src.push_back(int'(bus.src_id_o));
        obs_last.push_back(int'(bus.last_o));
        obs_data.push_back(int'(bus.data_o));
    endtask

    // One clock cycle against the reference model. Called at a negedge with
    // vld/word/out_rdy already set; returns at the next negedge.
    task automatic cycle();
        logic          acc;
        logic          alw;
        logic          gv;
        int            g;
        logic [NR-1:0] exp_rdy;
        drive();
        #1;
        acc = (exp_q.size() > 0) && out_rdy;
        alw = (exp_q.size() == 0) || (acc && exp_q[0][BW-1]);
        gv  = 1'b0;
        g   = 0;
        for (int i = 0; i < NR; i++) begin
            if (!gv && vld[(m_ptr + i) % NR]) begin
                gv = 1'b1;
                g  = (m_ptr + i) % NR;
            end
        end
        exp_rdy = (gv && alw) ? NR'(1 << g) : '0;
        chk("req_ready", 32'(bus.req_ready_o), 32'(exp_rdy));
        obs_rdy.push_back(int'(bus.req_ready_o));
        @(posedge clk);
        if (acc) void'(exp_q.pop_front());
        if (gv && alw) begin
            for (int k = 0; k < BEATS; k++) exp_q.push_back(make_beat(g, k));
            m_ptr = (g + 1) % NR;
        end
        @(negedge clk);
        check_outputs();
        if (gv && alw) begin
            if (keep[g]) word[g] = rand_word();
            else vld[g] = 1'b0;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cnt;
        logic [BI-1:0][DW-1:0] w;

        for (int g = 0; g < NR; g++) word[g] = '0;
        vld = '0; keep = '0; out_rdy = 1'b1;
        drive();
        do_reset();

        // Reset state
        chk("rst_valid", 32'(bus.data_valid_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_last", 32'(bus.last_o), 32'd0);
        chk("rst_src", 32'(bus.src_id_o), 32'd0);
        chk("rst_ptr", 32'(bus.dbg_rr_ptr), 32'd0);
        chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        chk("rst_ready", 32'(bus.req_ready_o), 32'd0);

        // Test 1: single request from req 2, table-driven
        for (int e = 0; e < BI; e++) word[2][e] = 8'h10 + 8'(e);
        tab[0] = '{4'b0100, 4'b0100, 1'b1, 8'h10, 8'h14, 1'b0, 1'b1, 2'd2};
        tab[1] = '{4'b0000, 4'b0000, 1'b1, 8'h11, 8'h15, 1'b0, 1'b1, 2'd2};
        tab[2] = '{4'b0000, 4'b0000, 1'b1, 8'h12, 8'h16, 1'b0, 1'b1, 2'd2};
        tab[3] = '{4'b0000, 4'b0000, 1'b1, 8'h13, 8'h17, 1'b1, 1'b1, 2'd2};
        tab[4] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2};
        tab[5] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd2};
        for (int i = 0; i < 6; i++) begin
            vld = tab[i].valid;
            drive();
            #1;
            chk("t1_ready", 32'(bus.req_ready_o), 32'(tab[i].rdy));
            @(posedge clk);
            @(negedge clk);
            chk("t1_valid", 32'(bus.data_valid_o), 32'(tab[i].dv));
            chk("t1_busy", 32'(bus.busy_o), 32'(tab[i].busy));
            chk("t1_last", 32'(bus.last_o), 32'(tab[i].last));
            if (tab[i].dv) begin
                chk("t1_d0", 32'(bus.data_o[0]), 32'(tab[i].d0));
                chk("t1_d1", 32'(bus.data_o[1]), 32'(tab[i].d1));
                chk("t1_src", 32'(bus.src_id_o), 32'(tab[i].src));
            end
        end
        chk("t1_ptr", 32'(bus.dbg_rr_ptr), 32'd3);

        // Test 2: all four valid from reset
        do_reset();
        for (int g = 0; g < NR; g++) word[g] = rand_word();
        vld = '1;
        clear_obs();
        for (int c = 0; c < 18; c++) cycle();
        for (int i = 0; i < 16; i++) begin
            chk("t2_valid", 32'(obs_v[i]), 32'd1);
            chk("t2_src", 32'(obs_src[i]), 32'(i / 4));
            chk("t2_last", 32'(obs_last[i]), 32'((i % 4) == 3));
        end
        chk("t2_idle_after", 32'(obs_v[16]), 32'd0);

        // Test 3: fairness between req0 and req3
        do_reset();
        word[0] = rand_word(); word[3] = rand_word();
        vld = 4'b1001; keep = 4'b1001;
        clear_obs();
        for (int c = 0; c < 16; c++) cycle();
        chk("t3_src0", 32'(obs_src[0]), 32'd0);
        chk("t3_src1", 32'(obs_src[4]), 32'd3);
        chk("t3_src2", 32'(obs_src[8]), 32'd0);
        chk("t3_src3", 32'(obs_src[12]), 32'd3);

        // Test 6: idle for 20 cycles keeps rr_ptr
        vld = '0; keep = '0;
        for (int c = 0; c < 6; c++) cycle();
        w[0] = 8'(m_ptr);
        clear_obs();
        for (int c = 0; c < 20; c++) cycle();
        cnt = 0;
        for (int i = 0; i < 20; i++) cnt += obs_v[i] + obs_rdy[i];
        chk("t6_quiet", 32'(cnt), 32'd0);
        chk("t6_ptr", 32'(bus.dbg_rr_ptr), 32'(w[0]));

        // Test 4: reset during beat 2 of a word from req1
        do_reset();
        word[1] = rand_word();
        vld = 4'b0010; keep = 4'b0010;
        cycle();
        cycle();
        chk("t4_beat2_valid", 32'(bus.data_valid_o), 32'd1);
        reset = 1'b1;
        #1;
        chk("t4_rst_valid", 32'(bus.data_valid_o), 32'd0);
        chk("t4_rst_busy", 32'(bus.busy_o), 32'd0);
        chk("t4_rst_last", 32'(bus.last_o), 32'd0);
        chk("t4_rst_ready", 32'(bus.req_ready_o), 32'd0);
        exp_q.delete();
        m_ptr = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        keep = '0;
        w = word[1];
        clear_obs();
        for (int c = 0; c < 6; c++) cycle();
        chk("t4_regrant", 32'(obs_rdy[0]), 32'b0010);
        chk("t4_d0", 32'(obs_data[0]), 32'({w[4], w[0]}));
        chk("t4_src", 32'(obs_src[0]), 32'd1);
        chk("t4_last", 32'(obs_last[3]), 32'd1);

`ifdef P2S_SCHED_BACKPRESSURE_EN
        // Test 5: beat 1 stalled for 3 cycles
        do_reset();
        for (int e = 0; e < BI; e++) word[0][e] = 8'h20 + 8'(e);
        word[1] = rand_word();
        vld = 4'b0011;
        clear_obs();
        for (int c = 0; c < 12; c++) begin
            out_rdy = !(c >= 1 && c <= 3);
            cycle();
        end
        out_rdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) cnt += (obs_v[i] != 0 && obs_src[i] == 0) ? 1 : 0;
        chk("t5_valid_cycles", 32'(cnt), 32'd7);
        for (int i = 0; i < 4; i++) chk("t5_hold", 32'(obs_data[i]), 32'h2420);
        chk("t5_last", 32'(obs_last[6]), 32'd1);
        cnt = 0;
        for (int i = 1; i < 7; i++) cnt += (obs_rdy[i] != 0) ? 1 : 0;
        chk("t5_no_grant", 32'(cnt), 32'd0);
        chk("t5_regrant", 32'(obs_rdy[7]), 32'b0010);
`endif

        // Random traffic against the reference model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int g = 0; g < NR; g++) begin
                if (!vld[g] && $urandom_range(0, 2) == 0) begin
                    vld[g]  = 1'b1;
                    word[g] = rand_word();
                    keep[g] = ($urandom_range(0, 3) == 0);
                end
            end
`ifdef P2S_SCHED_BACKPRESSURE_EN
            out_rdy = ($urandom_range(0, 3) != 0);
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
